// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point datapath blocks.
// Encoding helpers are functions because the formats are chosen per instance.
package fp_pkg;

  localparam int unsigned FP32_EW = 8;
  localparam int unsigned FP32_MW = 23;

  localparam int unsigned FLGW   = 4;
  localparam int unsigned FLG_NV = 3;
  localparam int unsigned FLG_OF = 2;
  localparam int unsigned FLG_UF = 1;
  localparam int unsigned FLG_NX = 0;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic sign;
  } fp_class_t;

  function automatic int unsigned bias_of(input int unsigned ew);
    return (32'd1 << (ew - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max_of(input int unsigned ew);
    return (32'd1 << ew) - 32'd1;
  endfunction

  // Canonical NaN without the sign bit: exponent all-ones, mantissa = 1.
  function automatic logic [63:0] qnan(input int unsigned ew, input int unsigned mw);
    return (((64'd1 << ew) - 64'd1) << mw) | 64'd1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final rounding, range check and packing of a normalised significand into an IEEE-style word.
// Purely combinational so it can sit behind any pipeline register.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int unsigned EW    = FP32_EW,
  parameter int unsigned MW    = FP32_MW,
  parameter int unsigned ROUND = 1
) (
  input  logic                   [MW-1:0]      mant,
  input  logic                                 g,
  input  logic                                 s,
  input  logic signed            [EW+1:0]      exp_in,
  input  fp_class_t                            cls,
  input  logic                                 nv,
  output logic                   [EW+MW:0]     y_c,
  output logic                   [FLGW-1:0]    flags_c
);

  localparam int unsigned XW      = EW + 2;
  localparam int unsigned EXP_MAX = exp_max_of(EW);
  localparam logic [EW+MW-1:0] QNAN = (EW+MW)'(qnan(EW, MW));
  localparam bit RNE = (ROUND != 0);

  logic                 inc;
  logic [MW:0]          sum;
  logic [MW-1:0]        mant_r;
  logic signed [XW-1:0] e_fin;
  logic                 ovf;
  logic                 unf;

  // Round, renormalise on carry-out, then re-check the exponent range.
  always_comb begin
    inc    = RNE && g && (s || mant[0]);
    sum    = {1'b0, mant} + (MW+1)'(inc);
    mant_r = sum[MW-1:0];
    e_fin  = exp_in + XW'(sum[MW]);
    ovf    = (e_fin >= $signed(XW'(EXP_MAX)));
    unf    = (e_fin <= $signed(XW'(0)));
  end

  always_comb begin
    y_c     = '0;
    flags_c = '0;
    if (cls.nan) begin
      y_c             = {cls.sign, QNAN};
      flags_c[FLG_NV] = nv;
    end else if (cls.inf) begin
      y_c = {cls.sign, {EW{1'b1}}, {MW{1'b0}}};
    end else if (cls.zero) begin
      y_c = {cls.sign, {(EW+MW){1'b0}}};
    end else if (ovf) begin
      y_c             = {cls.sign, {EW{1'b1}}, {MW{1'b0}}};
      flags_c[FLG_OF] = 1'b1;
      flags_c[FLG_NX] = 1'b1;
    end else if (unf) begin
      y_c             = {cls.sign, {(EW+MW){1'b0}}};
      flags_c[FLG_UF] = 1'b1;
      flags_c[FLG_NX] = 1'b1;
    end else begin
      y_c             = {cls.sign, e_fin[EW-1:0], mant_r};
      flags_c[FLG_NX] = g || s;
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier (classify/multiply, normalise, round/pack)
// with a single global stall driven by the output handshake.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int unsigned EW    = FP32_EW,
  parameter int unsigned MW    = FP32_MW,
  parameter int unsigned TAGW  = 4,
  parameter int unsigned ROUND = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [EW+MW:0]      a,
  input  logic [EW+MW:0]      b,
  input  logic [TAGW-1:0]     in_tag,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [EW+MW:0]      y,
  output logic [TAGW-1:0]     y_tag,
  output logic [FLGW-1:0]     y_flags,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int unsigned W    = 1 + EW + MW;
  localparam int unsigned PW   = 2 * MW + 2;
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned BIAS = bias_of(EW);

  logic en;

  assign en       = !y_valid || y_ready;
  assign in_ready = en;

  // ---------------- stage 1: classify and multiply ----------------
  logic [EW-1:0]        ea, eb;
  logic [MW-1:0]        ma, mb;
  fp_class_t            ca, cb, c1_n;
  logic                 inv_n;
  logic [PW-1:0]        prod_n;
  logic signed [XW-1:0] exp1_n;

  always_comb begin
    ea      = a[MW +: EW];
    eb      = b[MW +: EW];
    ma      = a[MW-1:0];
    mb      = b[MW-1:0];
    ca.zero = (ea == '0);
    ca.inf  = (ea == '1) && (ma == '0);
    ca.nan  = (ea == '1) && (ma != '0);
    ca.sign = a[W-1];
    cb.zero = (eb == '0);
    cb.inf  = (eb == '1) && (mb == '0);
    cb.nan  = (eb == '1) && (mb != '0);
    cb.sign = b[W-1];
    inv_n     = (ca.inf && cb.zero) || (ca.zero && cb.inf);
    c1_n.nan  = ca.nan || cb.nan || inv_n;
    c1_n.inf  = (ca.inf || cb.inf) && !c1_n.nan;
    c1_n.zero = (ca.zero || cb.zero) && !c1_n.nan && !c1_n.inf;
    c1_n.sign = ca.sign ^ cb.sign;
    prod_n    = PW'({1'b1, ma}) * PW'({1'b1, mb});
    exp1_n    = XW'(ea) + XW'(eb) - XW'(BIAS);
  end

  logic                 v1;
  logic [TAGW-1:0]      tag1;
  fp_class_t            c1;
  logic                 nv1;
  logic [PW-1:0]        prod1;
  logic signed [XW-1:0] exp1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      tag1  <= '0;
      c1    <= '0;
      nv1   <= 1'b0;
      prod1 <= '0;
      exp1  <= '0;
    end else if (en) begin
      v1    <= in_valid;
      tag1  <= in_tag;
      c1    <= c1_n;
      nv1   <= inv_n;
      prod1 <= prod_n;
      exp1  <= exp1_n;
    end
  end

  // ---------------- stage 2: normalise to 1.xxx, extract guard/sticky ----------------
  logic [PW-2:0]        norm;
  logic [MW-1:0]        mant2_n;
  logic                 g2_n, s2_n;
  logic signed [XW-1:0] exp2_n;

  always_comb begin
    norm    = prod1[PW-1] ? prod1[PW-2:0] : {prod1[PW-3:0], 1'b0};
    mant2_n = norm[PW-2 -: MW];
    g2_n    = norm[MW];
    s2_n    = |norm[MW-1:0];
    exp2_n  = exp1 + XW'(prod1[PW-1]);
  end

  logic                 v2;
  logic [TAGW-1:0]      tag2;
  fp_class_t            c2;
  logic                 nv2;
  logic [MW-1:0]        mant2;
  logic                 g2, s2;
  logic signed [XW-1:0] exp2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      tag2  <= '0;
      c2    <= '0;
      nv2   <= 1'b0;
      mant2 <= '0;
      g2    <= 1'b0;
      s2    <= 1'b0;
      exp2  <= '0;
    end else if (en) begin
      v2    <= v1;
      tag2  <= tag1;
      c2    <= c1;
      nv2   <= nv1;
      mant2 <= mant2_n;
      g2    <= g2_n;
      s2    <= s2_n;
      exp2  <= exp2_n;
    end
  end

  // ---------------- stage 3: round and pack into the output register ----------------
  logic [W-1:0]    y_n;
  logic [FLGW-1:0] flags_n;

  fp_round_pack #(
    .EW    (EW),
    .MW    (MW),
    .ROUND (ROUND)
  ) u_round_pack (
    .mant    (mant2),
    .g       (g2),
    .s       (s2),
    .exp_in  (exp2),
    .cls     (c2),
    .nv      (nv2),
    .y_c     (y_n),
    .flags_c (flags_n)
  );

  // Bubbles load zeros so that flags (and data) read as zero whenever y_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid <= 1'b0;
      y       <= '0;
      y_tag   <= '0;
      y_flags <= '0;
    end else if (en) begin
      y_valid <= v2;
      y       <= v2 ? y_n : '0;
      y_tag   <= v2 ? tag2 : '0;
      y_flags <= v2 ? flags_n : '0;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench: FP32 round-nearest-even, FP32 truncate and BF16 instances fed in
// lockstep, checked against an integer-arithmetic reference model and directed vectors.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [15:0] a16, b16;
  logic [3:0]  in_tag;
  logic        in_valid, y_ready;

  logic        ir, irt, irh;
  logic [31:0] y32, y32t;
  logic [15:0] y16;
  logic [3:0]  tg, tgt, tgh;
  logic [3:0]  fl, flt, flh;
  logic        yv, yvt, yvh;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EW(8), .MW(23), .TAGW(4), .ROUND(1)) u_f32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(ir), .y(y32), .y_tag(tg), .y_flags(fl), .y_valid(yv), .y_ready(y_ready));

  fp_mult_pipe #(.EW(8), .MW(23), .TAGW(4), .ROUND(0)) u_t32 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(irt), .y(y32t), .y_tag(tgt), .y_flags(flt), .y_valid(yvt), .y_ready(y_ready));

  fp_mult_pipe #(.EW(8), .MW(7), .TAGW(4), .ROUND(1)) u_b16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .in_tag(in_tag), .in_valid(in_valid),
    .in_ready(irh), .y(y16), .y_tag(tgh), .y_flags(flh), .y_valid(yvh), .y_ready(y_ready));

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;
    logic [31:0] yt;
    logic [3:0]  ft;
    logic [15:0] yh;
    logic [3:0]  fh;
    logic [3:0]  tag;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          nout  = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_y;
  logic [3:0]  hold_tag;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
    end
  endtask

  // Exact integer-significand product, rounded by comparing the discarded remainder with one half.
  function automatic logic [67:0] ref_mul(input int ew, input int mw, input bit rnd,
                                          input logic [63:0] x, input logic [63:0] z);
    logic [63:0] emax, mmask, ma, mb, ea, eb, sgn, sig, qq, rem, half, yy;
    longint      bias, e;
    int          sh;
    bit          top, za, zb, ia, ib, na, nb, inv;
    logic [3:0]  f;
    emax  = (64'd1 << ew) - 64'd1;
    mmask = (64'd1 << mw) - 64'd1;
    bias  = (longint'(1) << (ew - 1)) - 1;
    ma    = x & mmask;
    mb    = z & mmask;
    ea    = (x >> mw) & emax;
    eb    = (z >> mw) & emax;
    sgn   = 64'(x[ew+mw] ^ z[ew+mw]) << (ew + mw);
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == emax) && (ma == 0);  ib = (eb == emax) && (mb == 0);
    na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
    inv = (ia && zb) || (za && ib);
    f = 4'b0000;
    if (na || nb || inv) begin
      yy   = sgn | (emax << mw) | 64'd1;
      f[3] = inv;
    end else if (ia || ib) begin
      yy = sgn | (emax << mw);
    end else if (za || zb) begin
      yy = sgn;
    end else begin
      sig  = ((64'd1 << mw) | ma) * ((64'd1 << mw) | mb);
      top  = ((sig >> (2 * mw + 1)) != 0);
      sh   = mw + int'(top);
      e    = longint'(ea) + longint'(eb) - bias + longint'(top);
      qq   = sig >> sh;
      rem  = sig & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rnd && ((rem > half) || ((rem == half) && qq[0]))) qq = qq + 64'd1;
      if (qq == (64'd1 << (mw + 1))) begin
        qq = qq >> 1;
        e  = e + 1;
      end
      f[0] = (rem != 0);
      if (e >= longint'(emax)) begin
        yy = sgn | (emax << mw);
        f  = 4'b0101;
      end else if (e <= 0) begin
        yy = sgn;
        f  = 4'b0011;
      end else begin
        yy = sgn | (64'(e) << mw) | (qq & mmask);
      end
    end
    return {f, yy};
  endfunction

  // Operand generator biased toward zeros, infinities, NaNs and extreme exponents.
  function automatic logic [63:0] rnd_op(input int ew, input int mw);
    logic [63:0] emax, m, e, s;
    int          k;
    emax = (64'd1 << ew) - 64'd1;
    m    = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
    s    = 64'($urandom_range(0, 1));
    k    = int'($urandom_range(0, 15));
    case (k)
      0:       e = 64'd0;
      1:       begin e = emax; m = 64'd0; end
      2:       begin e = emax; m = m | 64'd1; end
      3:       e = 64'($urandom_range(1, 8));
      4:       e = emax - 64'($urandom_range(1, 8));
      default: e = 64'($urandom_range(1, 32'(emax - 64'd1)));
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  // One clock of the scoreboard: sample handshakes, check/pop outputs, push accepted inputs.
  task automatic cycle(output bit acc);
    exp_t        e;
    logic [67:0] r;
    #1;
    chk("valid_agree", {63'd0, yvt & yvh}, {63'd0, yv});
    chk("ready_agree", {62'd0, irt, irh}, {62'd0, ir, ir});
    if (!yv) chk("idle_flags", {48'd0, fl, flt, flh, tg}, 64'd0);
    if (hold_v) begin
      chk("stall_valid", {63'd0, yv}, 64'd1);
      chk("stall_y", {32'd0, y32}, {32'd0, hold_y});
      chk("stall_tag", {60'd0, tg}, {60'd0, hold_tag});
    end
    if (yv && y_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", {63'd0, yv}, 64'd0);
      end else begin
        e = q.pop_front();
        nout++;
        chk("y32", {32'd0, y32}, {32'd0, e.y});
        chk("flags32", {60'd0, fl}, {60'd0, e.f});
        chk("y32_trunc", {32'd0, y32t}, {32'd0, e.yt});
        chk("flags32_trunc", {60'd0, flt}, {60'd0, e.ft});
        chk("y16", {48'd0, y16}, {48'd0, e.yh});
        chk("flags16", {60'd0, flh}, {60'd0, e.fh});
        chk("tag", {52'd0, tg, tgt, tgh}, {52'd0, e.tag, e.tag, e.tag});
      end
    end
    acc = in_valid && ir;
    if (acc) begin
      r = ref_mul(8, 23, 1'b1, {32'd0, a}, {32'd0, b});
      e.y = r[31:0];  e.f = r[67:64];
      r = ref_mul(8, 23, 1'b0, {32'd0, a}, {32'd0, b});
      e.yt = r[31:0]; e.ft = r[67:64];
      r = ref_mul(8, 7, 1'b1, {48'd0, a16}, {48'd0, b16});
      e.yh = r[15:0]; e.fh = r[67:64];
      e.tag = in_tag;
      q.push_back(e);
    end
    hold_v   = yv && !y_ready;
    hold_y   = y32;
    hold_tag = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] t);
    bit acc;
    a = xa; b = xb; in_tag = t; in_valid = 1'b1;
    a16 = rnd_op(8, 7)[15:0];
    b16 = rnd_op(8, 7)[15:0];
    cycle(acc);
    chk("send_accepted", {63'd0, acc}, 64'd1);
  endtask

  // Single product with exact 3-cycle latency and hard-coded results for both rounding modes.
  task automatic vec(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                     input logic [31:0] ey, input logic [3:0] ef,
                     input logic [31:0] eyt, input logic [3:0] eft);
    bit acc;
    y_ready = 1'b1;
    send(xa, xb, 4'd9);
    in_valid = 1'b0;
    chk({nm, "_lat1"}, {63'd0, yv}, 64'd0);
    cycle(acc);
    chk({nm, "_lat2"}, {63'd0, yv}, 64'd0);
    cycle(acc);
    chk({nm, "_lat3"}, {63'd0, yv}, 64'd1);
    chk({nm, "_y"}, {32'd0, y32}, {32'd0, ey});
    chk({nm, "_f"}, {60'd0, fl}, {60'd0, ef});
    chk({nm, "_yt"}, {32'd0, y32t}, {32'd0, eyt});
    chk({nm, "_ft"}, {60'd0, flt}, {60'd0, eft});
    cycle(acc);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    y_ready  = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(acc);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    bit acc;
    int sent, cyc, n0;
    rst = 1'b1; a = '0; b = '0; a16 = '0; b16 = '0; in_tag = '0;
    in_valid = 1'b0; y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {63'd0, yv}, 64'd0);
    chk("rst_out", {28'd0, y32, tg}, 64'd0);
    chk("rst_flags", {60'd0, fl}, 64'd0);
    chk("rst_in_ready", {63'd0, ir}, 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vec("t1", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 32'h40400000, 4'b0000);
    vec("t2", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 32'h3FC00001, 4'b0001);
    vec("inf_x_0", 32'h7F800000, 32'h00000000, 32'h7F800001, 4'b1000, 32'h7F800001, 4'b1000);
    vec("ninf_x_2", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 32'hFF800000, 4'b0000);
    vec("nan_x_1", 32'h7FC00000, 32'h3F800000, 32'h7F800001, 4'b0000, 32'h7F800001, 4'b0000);
    vec("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 32'h7F800000, 4'b0101);
    vec("unf", 32'h00800000, 32'h80800000, 32'h80000000, 4'b0011, 32'h80000000, 4'b0011);
    vec("ftz", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 32'h00000000, 4'b0000);

    // Back-to-back tags 0..15 with a 5-cycle consumer stall in the middle.
    n0 = nout; sent = 0; cyc = 0;
    while (sent < 16 && cyc < 100) begin
      y_ready  = !(cyc >= 5 && cyc < 10);
      in_valid = 1'b1;
      in_tag   = 4'(sent);
      a = rnd_op(8, 23)[31:0];  b = rnd_op(8, 23)[31:0];
      a16 = rnd_op(8, 7)[15:0]; b16 = rnd_op(8, 7)[15:0];
      #1;
      if (cyc >= 5 && cyc < 10) chk("stall_in_ready", {63'd0, ir}, 64'd0);
      cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'd16);
    drain();
    chk("stream_count", 64'(nout - n0), 64'd16);

    // Reset with three products in flight.
    y_ready = 1'b1;
    send(32'h40000000, 32'h40000000, 4'd1);
    send(32'h40400000, 32'h40000000, 4'd2);
    send(32'h40800000, 32'h40000000, 4'd3);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {63'd0, yv}, 64'd0);
    chk("rst_mid_out", {28'd0, y32, tg}, 64'd0);
    q.delete();
    hold_v = 1'b0;
    cycle(acc);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(acc);
      chk("no_stale", {63'd0, yv}, 64'd0);
    end
    vec("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 32'h40400000, 4'b0000);

    // Random traffic with random source gaps and consumer stalls.
    sent = 0; cyc = 0;
    while (sent < 1000 && cyc < 6000) begin
      in_valid = ($urandom_range(0, 9) < 8);
      y_ready  = ($urandom_range(0, 3) != 0);
      in_tag   = 4'($urandom);
      a = rnd_op(8, 23)[31:0];  b = rnd_op(8, 23)[31:0];
      a16 = rnd_op(8, 7)[15:0]; b16 = rnd_op(8, 7)[15:0];
      cycle(acc);
      if (acc) sent++;
      cyc++;
    end
    chk("random_sent", 64'(sent), 64'd1000);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
